// File: rtl/pixel_threshold_stream.sv
// pixel_threshold_stream: RGB888 Avalon-ST to 30-bit luma threshold/grey stream
// Ports: clk_clk/reset_reset_n (sync, active-low); in_* RGB888 sink with SOP/EOP;
// out_* 10:10:10 source with SOP/EOP; threshold/mode/invert latched per frame on SOP;
// frame_error pulses on dropped beats and wrong-length frames.
// Optional: define PIXEL_THRESHOLD_STATS_EN for white_count/white_count_valid.
module pixel_threshold_stream #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int CNT_W  = 17
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [23:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_startofpacket,
  input  logic             in_endofpacket,
  output logic [29:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_startofpacket,
  output logic             out_endofpacket,
  input  logic [7:0]       threshold,
  input  logic             mode,
  input  logic             invert,
`ifdef PIXEL_THRESHOLD_STATS_EN
  output logic [CNT_W-1:0] white_count,
  output logic             white_count_valid,
`endif
  output logic             frame_error
);
  localparam logic [CNT_W-1:0] TOTAL = CNT_W'(WIDTH * HEIGHT);
  typedef enum logic {WAIT_SOP, IN_FRAME} state_e;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0] thr_q, thr_d;
  logic mode_q, mode_d, inv_q, inv_d;
  logic s1_valid_q, s1_valid_d, s1_sop_q, s1_sop_d, s1_eop_q, s1_eop_d;
  logic [7:0] s1_y_q, s1_y_d, s1_thr_q, s1_thr_d;
  logic s1_mode_q, s1_mode_d, s1_inv_q, s1_inv_d;
  logic out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
  logic [29:0] out_data_q, out_data_d, fmt;
  logic frame_error_q, frame_error_d;
  logic en, acc, fwd, err, pix, ld2;
  logic [15:0] luma_sum;
  assign en = !out_valid_q | out_ready;
  assign in_ready = reset_reset_n & en;
  assign acc = in_valid & in_ready;
  assign luma_sum = 16'd77 * {8'd0, in_data[23:16]} + 16'd150 * {8'd0, in_data[15:8]}
                  + 16'd29 * {8'd0, in_data[7:0]};
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    thr_d = thr_q;
    mode_d = mode_q;
    inv_d = inv_q;
    fwd = 1'b0;
    err = 1'b0;
    if (acc && in_startofpacket) begin
      thr_d = threshold;
      mode_d = mode;
      inv_d = invert;
      fwd = 1'b1;
      cnt_d = CNT_W'(1);
      err = (state_q == IN_FRAME) | (in_endofpacket & (TOTAL != CNT_W'(1)));
      state_d = in_endofpacket ? WAIT_SOP : IN_FRAME;
    end else if (acc && state_q == WAIT_SOP) begin
      err = 1'b1;
    end else if (acc) begin
      fwd = 1'b1;
      cnt_d = cnt_inc;
      err = in_endofpacket & (cnt_inc != TOTAL);
      state_d = in_endofpacket ? WAIT_SOP : IN_FRAME;
    end
  end
  // Config travels with each beat so a new SOP behind an older frame cannot retarget it.
  always_comb begin
    s1_valid_d = en ? fwd : s1_valid_q;
    s1_sop_d = en ? in_startofpacket : s1_sop_q;
    s1_eop_d = en ? in_endofpacket : s1_eop_q;
    s1_y_d = en ? luma_sum[15:8] : s1_y_q;
    s1_thr_d = en ? thr_d : s1_thr_q;
    s1_mode_d = en ? mode_d : s1_mode_q;
    s1_inv_d = en ? inv_d : s1_inv_q;
    pix = (s1_y_q >= s1_thr_q) ^ s1_inv_q;
    fmt = s1_mode_q ? {3{s1_y_q, s1_y_q[7:6]}} : {30{pix}};
    ld2 = en & s1_valid_q;
    out_valid_d = en ? s1_valid_q : out_valid_q;
    out_data_d = ld2 ? fmt : out_data_q;
    out_sop_d = en ? s1_valid_q & s1_sop_q : out_sop_q;
    out_eop_d = en ? s1_valid_q & s1_eop_q : out_eop_q;
    frame_error_d = err;
  end
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q <= WAIT_SOP;
      cnt_q <= '0;
      thr_q <= 8'h80;
      mode_q <= 1'b0;
      inv_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_sop_q <= 1'b0;
      s1_eop_q <= 1'b0;
      s1_y_q <= '0;
      s1_thr_q <= 8'h80;
      s1_mode_q <= 1'b0;
      s1_inv_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sop_q <= 1'b0;
      out_eop_q <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      thr_q <= thr_d;
      mode_q <= mode_d;
      inv_q <= inv_d;
      s1_valid_q <= s1_valid_d;
      s1_sop_q <= s1_sop_d;
      s1_eop_q <= s1_eop_d;
      s1_y_q <= s1_y_d;
      s1_thr_q <= s1_thr_d;
      s1_mode_q <= s1_mode_d;
      s1_inv_q <= s1_inv_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_sop_q <= out_sop_d;
      out_eop_q <= out_eop_d;
      frame_error_q <= frame_error_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket = out_eop_q;
  assign frame_error = frame_error_q;
`ifdef PIXEL_THRESHOLD_STATS_EN
  logic out_pix_q, out_pix_d, wcv_q, wcv_d, xfer;
  logic [CNT_W-1:0] run_q, run_d, run_new, wc_q, wc_d;
  // White pixels are tallied as they leave, so the total is ready on the EOP transfer.
  always_comb begin
    out_pix_d = ld2 ? (!s1_mode_q & pix) : out_pix_q;
    xfer = out_valid_q & out_ready;
    run_new = out_sop_q ? CNT_W'(out_pix_q) : run_q + CNT_W'(out_pix_q);
    run_d = xfer ? run_new : run_q;
    wc_d = (xfer & out_eop_q) ? run_new : wc_q;
    wcv_d = xfer & out_eop_q;
  end
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      out_pix_q <= 1'b0;
      run_q <= '0;
      wc_q <= '0;
      wcv_q <= 1'b0;
    end else begin
      out_pix_q <= out_pix_d;
      run_q <= run_d;
      wc_q <= wc_d;
      wcv_q <= wcv_d;
    end
  end
  assign white_count = wc_q;
  assign white_count_valid = wcv_q;
`endif
endmodule

// File: tb/tb_pixel_threshold_stream.sv
// tb_pixel_threshold_stream: directed scoreboard bench for pixel_threshold_stream on a 4x2 frame
module tb_pixel_threshold_stream;
  localparam int W = 4, H = 2, CW = 4;
  localparam logic [29:0] ONES = 30'h3FFFFFFF;
  logic clk_clk = 1'b0, reset_reset_n = 1'b0;
  logic [23:0] in_data = '0;
  logic in_valid = 1'b0, in_startofpacket = 1'b0, in_endofpacket = 1'b0;
  logic in_ready, out_valid, out_startofpacket, out_endofpacket, frame_error;
  logic out_ready = 1'b1;
  logic [29:0] out_data;
  logic [7:0] threshold = 8'h80;
  logic mode = 1'b0, invert = 1'b0;
`ifdef PIXEL_THRESHOLD_STATS_EN
  logic [CW-1:0] white_count;
  logic white_count_valid;
`endif
  pixel_threshold_stream #(.WIDTH(W), .HEIGHT(H), .CNT_W(CW)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
    .threshold(threshold), .mode(mode), .invert(invert),
`ifdef PIXEL_THRESHOLD_STATS_EN
    .white_count(white_count), .white_count_valid(white_count_valid),
`endif
    .frame_error(frame_error));
  always #5 clk_clk = ~clk_clk;
  typedef struct {logic sop; logic eop; logic [29:0] data; int acc; logic [CW-1:0] wc;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, err_cnt = 0, out_cnt = 0, cyc = 0, e0, o0;
  logic bp = 1'b0, rnd = 1'b0;
  logic [CW-1:0] wc_run = '0;
  logic [23:0] pe [4] = '{24'h808080, 24'h102030, 24'hFF0000, 24'hFFFFFF};
  logic [29:0] xe [4] = '{{3{10'h202}}, {3{10'h074}}, {3{10'h131}}, 30'h3FFFFFFF};
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_clk);
    #1;
    if (bp) out_ready = ~out_ready;
  endtask
  task automatic send(input logic [23:0] d, input logic s, input logic e, input logic [7:0] th,
                      input logic m, input logic iv, input logic fwd, input logic [29:0] xd);
    logic got;
    int a;
    if (rnd) repeat ($urandom_range(0, 2)) tick();
    in_data = d; in_startofpacket = s; in_endofpacket = e;
    threshold = th; mode = m; invert = iv; in_valid = 1'b1;
    got = 1'b0;
    a = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk_clk);
      got = in_ready;
      a = cyc;
      tick();
    end
    chk("accept", 64'(got), 1);
    in_valid = 1'b0;
    if (fwd) begin
      wc_run = s ? CW'(!m && xd == ONES) : wc_run + CW'(!m && xd == ONES);
      q.push_back('{s, e, xd, a, wc_run});
    end
  endtask
  initial forever begin
    @(posedge clk_clk);
    cyc++;
  end
  initial begin
    logic held, wc_pend;
    logic [32:0] hold;
    logic [CW-1:0] wc_exp;
    exp_t x;
    held = 1'b0; wc_pend = 1'b0; hold = '0; wc_exp = '0;
    forever begin
      @(negedge clk_clk);
      if (!reset_reset_n) begin
        held = 1'b0;
        wc_pend = 1'b0;
      end else begin
        if (frame_error) err_cnt++;
        if (held) chk("stable", {31'd0, out_valid, out_startofpacket, out_endofpacket, out_data}, {31'd0, hold});
        held = out_valid & ~out_ready;
        hold = {out_valid, out_startofpacket, out_endofpacket, out_data};
`ifdef PIXEL_THRESHOLD_STATS_EN
        if (wc_pend) begin
          chk("wc_valid", 64'(white_count_valid), 1);
          chk("white_count", 64'(white_count), 64'(wc_exp));
        end else if (white_count_valid) chk("wc_spurious", 64'(white_count_valid), 0);
`endif
        wc_pend = 1'b0;
        if (out_valid && out_ready) begin
          out_cnt++;
          if (q.size() == 0) chk("beat_expected", 64'(q.size()), 1);
          else begin
            x = q.pop_front();
            chk("data", 64'(out_data), 64'(x.data));
            chk("sop", 64'(out_startofpacket), 64'(x.sop));
            chk("eop", 64'(out_endofpacket), 64'(x.eop));
            if (!bp) chk("latency", 64'(cyc - x.acc), 2);
            if (x.eop) begin
              wc_pend = 1'b1;
              wc_exp = x.wc;
            end
          end
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not end, required end of test");
    $fatal(1);
  end
  initial begin
    repeat (3) tick();
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data", 64'(out_data), 0);
    chk("rst_sop_eop", {62'd0, out_startofpacket, out_endofpacket}, 0);
    chk("rst_frame_error", 64'(frame_error), 0);
`ifdef PIXEL_THRESHOLD_STATS_EN
    chk("rst_white_count", {59'd0, white_count_valid, white_count}, 0);
`endif
    reset_reset_n = 1'b1;
    tick();
    chk("ready_after_rst", 64'(in_ready), 1);
    for (int i = 0; i < 8; i++)
      send(i % 2 ? 24'h0 : 24'hFFFFFF, i == 0, i == 7, 8'h80, 0, 0, 1, i % 2 ? 30'h0 : ONES);
    repeat (6) tick();
    chk("t1_beats", 64'(out_cnt), 8);
    chk("t1_err", 64'(err_cnt), 0);
    bp = 1'b1; rnd = 1'b1;
    for (int i = 0; i < 8; i++)
      send(i % 2 ? 24'h0 : 24'hFFFFFF, i == 0, i == 7, 8'h80, 0, 0, 1, i % 2 ? 30'h0 : ONES);
    bp = 1'b0; rnd = 1'b0; out_ready = 1'b1;
    repeat (6) tick();
    chk("t2_beats", 64'(out_cnt), 16);
    chk("t2_left", 64'(q.size()), 0);
    chk("t2_err", 64'(err_cnt), 0);
    e0 = err_cnt;
    send(24'h808080, 1, 0, 8'h80, 0, 0, 1, ONES);
    send(24'h808080, 0, 0, 8'hFF, 0, 0, 1, ONES);
    send(24'hFF0000, 0, 0, 8'hFF, 0, 0, 1, 30'h0);
    send(24'h102030, 0, 0, 8'h00, 0, 0, 1, 30'h0);
    send(24'hFFFFFF, 0, 0, 8'hFF, 1, 1, 1, ONES);
    send(24'h000000, 0, 0, 8'hFF, 0, 0, 1, 30'h0);
    send(24'h808080, 0, 0, 8'hFF, 0, 0, 1, ONES);
    send(24'h808080, 0, 1, 8'hFF, 0, 0, 1, ONES);
    for (int i = 0; i < 8; i++)
      send(i == 7 ? 24'h102030 : 24'hFF0000, i == 0, i == 7, i == 0 ? 8'h4C : 8'h4D, 0, 0, 1,
           i == 7 ? 30'h0 : ONES);
    send(24'hFF0000, 1, 1, 8'h4D, 0, 0, 1, 30'h0);
    chk("single_beat_fe", 64'(frame_error), 1);
    for (int i = 0; i < 8; i++)
      send(i % 2 ? 24'h0 : 24'hFFFFFF, i == 0, i == 7, 8'h80, 0, i == 0, 1, i % 2 ? ONES : 30'h0);
    for (int i = 0; i < 8; i++)
      send(pe[i % 4], i == 0, i == 7, 8'h10, i == 0, 0, 1, xe[i % 4]);
    repeat (6) tick();
    chk("t3_err", 64'(err_cnt - e0), 1);
    chk("t3_left", 64'(q.size()), 0);
    e0 = err_cnt;
    for (int i = 0; i < 7; i++)
      send(i % 2 ? 24'h0 : 24'hFFFFFF, i == 0, i == 6, 8'h80, 0, 0, 1, i % 2 ? 30'h0 : ONES);
    chk("short_fe_pulse", 64'(frame_error), 1);
    tick();
    chk("short_fe_drop", 64'(frame_error), 0);
    for (int i = 0; i < 8; i++)
      send(i % 2 ? 24'hFFFFFF : 24'h0, i == 0, i == 7, 8'h80, 0, 0, 1, i % 2 ? ONES : 30'h0);
    repeat (6) tick();
    chk("t4_err", 64'(err_cnt - e0), 1);
    out_ready = 1'b0;
    send(24'hFFFFFF, 1, 0, 8'h80, 0, 0, 0, 30'h0);
    send(24'hFFFFFF, 0, 0, 8'h80, 0, 0, 0, 30'h0);
    chk("stalled_valid", 64'(out_valid), 1);
    reset_reset_n = 1'b0;
    tick();
    chk("midrst_valid", 64'(out_valid), 0);
    chk("midrst_ready", 64'(in_ready), 0);
    reset_reset_n = 1'b1; out_ready = 1'b1;
    tick();
    e0 = err_cnt; o0 = out_cnt;
    for (int i = 0; i < 3; i++) send(24'hFFFFFF, 0, 0, 8'h80, 0, 0, 0, 30'h0);
    repeat (4) tick();
    chk("nosop_err", 64'(err_cnt - e0), 3);
    chk("nosop_fwd", 64'(out_cnt - o0), 0);
    e0 = err_cnt;
    for (int i = 0; i < 3; i++) send(24'hFFFFFF, i == 0, 0, 8'h80, 0, 0, 1, ONES);
    for (int i = 0; i < 8; i++)
      send(i % 2 ? 24'h0 : 24'hFFFFFF, i == 0, i == 7, 8'h80, 0, 0, 1, i % 2 ? 30'h0 : ONES);
    repeat (6) tick();
    chk("midsop_err", 64'(err_cnt - e0), 1);
    chk("final_left", 64'(q.size()), 0);
    chk("final_beats", 64'(out_cnt - o0), 11);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
